// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared state encoding and constant helpers for add_seq
package add_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_t;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Counter width never collapses to zero bits, even for a single chunk.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/add_seq_slice.sv
// rtl/add_seq_slice.sv - combinational CHUNK_WIDTH adder slice with carry in/out
module add_seq_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/add_seq.sv
// rtl/add_seq.sv - wide adder computed one chunk per cycle on a single narrow slice
module add_seq
    import add_seq_pkg::*;
#(
    parameter int A_WIDTH     = 32,
    parameter int B_WIDTH     = 32,
    parameter int Y_WIDTH     = 33,
    parameter bit A_SIGNED    = 1'b0,
    parameter bit B_SIGNED    = 1'b0,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_WIDTH-1:0] in_a,
    input  logic [B_WIDTH-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Y_WIDTH-1:0] out_y,
    output logic               busy
);

    localparam int N_CHUNKS   = ceil_div(Y_WIDTH, CHUNK_WIDTH);
    localparam int EXT_WIDTH  = N_CHUNKS * CHUNK_WIDTH;
    localparam int IDX_W      = clog2_min1(N_CHUNKS);
    localparam bit SIGNED_ADD = A_SIGNED && B_SIGNED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    state_t                 state_q, state_d;
    logic [EXT_WIDTH-1:0]   op_a_q, op_b_q, y_q;
    logic [EXT_WIDTH-1:0]   a_ext, b_ext;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_q;
    logic [CHUNK_WIDTH-1:0] a_chunk, b_chunk, sum_chunk;
    logic                   cout;
    logic                   accept;
    logic                   pad_a, pad_b;
    logic                   unused_bits;

    // Mixed signedness falls back to zero extension, matching the $add cell.
    assign pad_a = SIGNED_ADD ? in_a[A_WIDTH-1] : 1'b0;
    assign pad_b = SIGNED_ADD ? in_b[B_WIDTH-1] : 1'b0;

    for (genvar g = 0; g < EXT_WIDTH; g++) begin : g_ext
        if (g < A_WIDTH) begin : g_a_in
            assign a_ext[g] = in_a[g];
        end else begin : g_a_pad
            assign a_ext[g] = pad_a;
        end
        if (g < B_WIDTH) begin : g_b_in
            assign b_ext[g] = in_b[g];
        end else begin : g_b_pad
            assign b_ext[g] = pad_b;
        end
    end

    assign unused_bits = ^{in_a, in_b, y_q};

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_CALC);
    assign accept    = in_valid && in_ready;
    assign out_y     = y_q[Y_WIDTH-1:0];

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int c = 0; c < N_CHUNKS; c++) begin
            if (idx_q == IDX_W'(c)) begin
                a_chunk = op_a_q[c*CHUNK_WIDTH +: CHUNK_WIDTH];
                b_chunk = op_b_q[c*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    add_seq_slice #(
        .WIDTH(CHUNK_WIDTH)
    ) u_slice (
        .a   (a_chunk),
        .b   (b_chunk),
        .cin (carry_q),
        .sum (sum_chunk),
        .cout(cout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_CALC;
            S_CALC: if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = in_valid ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            op_a_q  <= a_ext;
            op_b_q  <= b_ext;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else if (state_q == S_CALC) begin
            for (int c = 0; c < N_CHUNKS; c++) begin
                if (idx_q == IDX_W'(c)) y_q[c*CHUNK_WIDTH +: CHUNK_WIDTH] <= sum_chunk;
            end
            carry_q <= cout;
            if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        end
    end

endmodule
